// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and operand/result bus for seq_divider.
interface seq_divider_if #(
  parameter int NDIVIDEND = 36,
  parameter int NDIVISOR  = 18
);
  logic                 START;
  logic [NDIVIDEND-1:0] DIVIDEND;
  logic [NDIVISOR-1:0]  DIVISOR;
  logic                 BUSY;
  logic                 DONE;
  logic [NDIVIDEND-1:0] QUOTIENT;
  logic [NDIVISOR-1:0]  REMAINDER;
  logic                 DIV_BY_ZERO;

  modport master (
    output START, DIVIDEND, DIVISOR,
    input  BUSY, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO
  );

  modport slave (
    input  START, DIVIDEND, DIVISOR,
    output BUSY, DONE, QUOTIENT, REMAINDER, DIV_BY_ZERO
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, MSB first.
// SEQ_DIVIDER_SIGNED_EN: two's-complement operands with a FIX sign-correction state.
module seq_divider #(
  parameter int NDIVIDEND = 36,
  parameter int NDIVISOR  = 18
) (
  input logic          CLK,
  input logic          RST_N,
  seq_divider_if.slave bus
);
  localparam int CW = $clog2(NDIVIDEND);
  localparam logic [CW-1:0] LAST = CW'(NDIVIDEND - 1);

`ifdef SEQ_DIVIDER_SIGNED_EN
  typedef enum logic [2:0] {IDLE, RUN, ZERO, FIX, FIN} state_t;
`else
  typedef enum logic [1:0] {IDLE, RUN, ZERO, FIN} state_t;
`endif

  state_t               state;
  logic [CW-1:0]        count;
  logic [NDIVISOR-1:0]  rem;
  logic [NDIVISOR-1:0]  dvsr;
  logic [NDIVIDEND-1:0] dq;
  logic [NDIVIDEND-1:0] opa;
  logic [NDIVISOR-1:0]  opb;
  logic [NDIVISOR:0]    rem_sh;
  logic [NDIVISOR-1:0]  rem_nx;
  logic [NDIVIDEND-1:0] dq_nx;
  logic                 q_bit;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic                 q_neg;
  logic                 r_neg;
`endif

  // Dividend shifts out of dq's MSB while quotient bits shift into its LSB.
  always_comb begin
`ifdef SEQ_DIVIDER_SIGNED_EN
    opa = bus.DIVIDEND[NDIVIDEND-1] ? -bus.DIVIDEND : bus.DIVIDEND;
    opb = bus.DIVISOR[NDIVISOR-1] ? -bus.DIVISOR : bus.DIVISOR;
`else
    opa = bus.DIVIDEND;
    opb = bus.DIVISOR;
`endif
    rem_sh = {rem, dq[NDIVIDEND-1]};
    q_bit  = (rem_sh >= {1'b0, dvsr});
    rem_nx = q_bit ? NDIVISOR'(rem_sh - {1'b0, dvsr}) : rem_sh[NDIVISOR-1:0];
    dq_nx  = {dq[NDIVIDEND-2:0], q_bit};
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state           <= IDLE;
      count           <= '0;
      rem             <= '0;
      dvsr            <= '0;
      dq              <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      q_neg           <= 1'b0;
      r_neg           <= 1'b0;
`endif
      bus.BUSY        <= 1'b0;
      bus.DONE        <= 1'b0;
      bus.QUOTIENT    <= '0;
      bus.REMAINDER   <= '0;
      bus.DIV_BY_ZERO <= 1'b0;
    end else begin
      case (state)
        IDLE, FIN: begin
          bus.DONE <= 1'b0;
          if (bus.START) begin
            dq              <= opa;
            dvsr            <= opb;
            rem             <= '0;
            count           <= '0;
            bus.DIV_BY_ZERO <= 1'b0;
            bus.BUSY        <= 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
            q_neg           <= bus.DIVIDEND[NDIVIDEND-1] ^ bus.DIVISOR[NDIVISOR-1];
            r_neg           <= bus.DIVIDEND[NDIVIDEND-1];
`endif
            state           <= (bus.DIVISOR == '0) ? ZERO : RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          dq    <= dq_nx;
          rem   <= rem_nx;
          count <= count + 1'b1;
          if (count == LAST) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            state <= FIX;
`else
            bus.QUOTIENT  <= dq_nx;
            bus.REMAINDER <= rem_nx;
            bus.DONE      <= 1'b1;
            bus.BUSY      <= 1'b0;
            state         <= FIN;
`endif
          end
        end
`ifdef SEQ_DIVIDER_SIGNED_EN
        FIX: begin
          bus.QUOTIENT  <= q_neg ? -dq : dq;
          bus.REMAINDER <= r_neg ? -rem : rem;
          bus.DONE      <= 1'b1;
          bus.BUSY      <= 1'b0;
          state         <= FIN;
        end
`endif
        ZERO: begin
          bus.QUOTIENT    <= '1;
          bus.REMAINDER   <= '0;
          bus.DIV_BY_ZERO <= 1'b1;
          bus.DONE        <= 1'b1;
          bus.BUSY        <= 1'b0;
          state           <= FIN;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_divider.sv
// Randomized self-checking bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
  localparam int NA = 36;
  localparam int NB = 18;

  logic CLK;
  logic RST_N;
  int   checks = 0;
  int   errors = 0;

  seq_divider_if #(.NDIVIDEND(NA), .NDIVISOR(NB)) dif ();

  seq_divider #(.NDIVIDEND(NA), .NDIVISOR(NB)) dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .bus   (dif.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [NA-1:0] a, input logic [NB-1:0] b,
                                output logic [NA-1:0] q, output logic [NB-1:0] r,
                                output logic z);
    if (b == '0) begin
      q = '1;
      r = '0;
      z = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = NA'(sa / sb);
      r  = NB'(sa % sb);
`else
      q  = a / NA'(b);
      r  = NB'(a % NA'(b));
`endif
      z = 1'b0;
    end
  endfunction

  function automatic int lat(input logic [NB-1:0] b);
`ifdef SEQ_DIVIDER_SIGNED_EN
    return (b == '0) ? 1 : NA + 1;
`else
    return (b == '0) ? 1 : NA;
`endif
  endfunction

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!dif.DONE && cyc < 200) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic check_result(input string tag, input logic [NA-1:0] a, input logic [NB-1:0] b);
    logic [NA-1:0] eq;
    logic [NB-1:0] er;
    logic          ez;
    model(a, b, eq, er, ez);
    check({tag, "_done"}, dif.DONE, 1'b1);
    check({tag, "_q"}, dif.QUOTIENT, eq);
    check({tag, "_r"}, dif.REMAINDER, er);
    check({tag, "_dbz"}, dif.DIV_BY_ZERO, ez);
    check({tag, "_busy_fin"}, dif.BUSY, 1'b0);
  endtask

  task automatic run_op(input string tag, input logic [NA-1:0] a, input logic [NB-1:0] b);
    int cyc;
    @(negedge CLK);
    dif.START    = 1'b1;
    dif.DIVIDEND = a;
    dif.DIVISOR  = b;
    @(negedge CLK);
    dif.START    = 1'b0;
    dif.DIVIDEND = {$urandom, $urandom};
    dif.DIVISOR  = NB'($urandom);
    check({tag, "_busy"}, dif.BUSY, 1'b1);
    wait_done(cyc);
    check({tag, "_lat"}, cyc, lat(b));
    check_result(tag, a, b);
    @(negedge CLK);
    check({tag, "_pulse"}, dif.DONE, 1'b0);
  endtask

  initial begin
    int cyc;
    int seen;
    logic [NA-1:0] ra;
    logic [NB-1:0] rb;

    RST_N        = 1'b0;
    dif.START    = 1'b0;
    dif.DIVIDEND = '0;
    dif.DIVISOR  = '0;
    repeat (3) @(negedge CLK);
    check("rst_busy", dif.BUSY, 1'b0);
    check("rst_done", dif.DONE, 1'b0);
    check("rst_q", dif.QUOTIENT, '0);
    check("rst_r", dif.REMAINDER, '0);
    check("rst_dbz", dif.DIV_BY_ZERO, 1'b0);
    RST_N = 1'b1;

    run_op("d100_7", 36'd100, 18'd7);
    run_op("dmax_1", 36'hFFFFFFFFF, 18'd1);
    run_op("d5_max", 36'd5, 18'h3FFFF);
    run_op("d1234_0", 36'd1234, 18'd0);

    // Back-to-back: mid-RUN START ignored, START held through FIN accepted.
    @(negedge CLK);
    dif.START = 1'b1; dif.DIVIDEND = 36'd100; dif.DIVISOR = 18'd7;
    @(negedge CLK);
    dif.START = 1'b0;
    repeat (10) @(negedge CLK);
    dif.START = 1'b1; dif.DIVIDEND = 36'd9; dif.DIVISOR = 18'd3;
    @(negedge CLK);
    dif.START = 1'b0;
    wait_done(cyc);
    check("b2b_lat1", cyc + 11, lat(18'd7));
    check_result("b2b_first", 36'd100, 18'd7);
    dif.START = 1'b1; dif.DIVIDEND = 36'd50; dif.DIVISOR = 18'd6;
    @(negedge CLK);
    dif.START = 1'b0;
    check("b2b_busy2", dif.BUSY, 1'b1);
    check("b2b_done_low", dif.DONE, 1'b0);
    wait_done(cyc);
    check("b2b_lat2", cyc, lat(18'd6));
    check_result("b2b_second", 36'd50, 18'd6);

    // Reset in the middle of an iteration aborts without DONE.
    @(negedge CLK);
    dif.START = 1'b1; dif.DIVIDEND = 36'd100; dif.DIVISOR = 18'd7;
    @(negedge CLK);
    dif.START = 1'b0;
    repeat (19) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    check("mid_rst_busy", dif.BUSY, 1'b0);
    check("mid_rst_done", dif.DONE, 1'b0);
    check("mid_rst_q", dif.QUOTIENT, '0);
    check("mid_rst_r", dif.REMAINDER, '0);
    check("mid_rst_dbz", dif.DIV_BY_ZERO, 1'b0);
    seen = 0;
    repeat (60) begin
      @(negedge CLK);
      if (dif.DONE) seen++;
    end
    check("mid_rst_no_done", seen, 0);
    run_op("d81_9", 36'd81, 18'd9);

`ifdef SEQ_DIVIDER_SIGNED_EN
    run_op("s_m100_7", -36'd100, 18'd7);
    run_op("s_100_m7", 36'd100, -18'd7);
    run_op("s_m100_m7", -36'd100, -18'd7);
    run_op("s_minneg_m1", {1'b1, 35'b0}, '1);
`endif

    for (int i = 0; i < 30; i++) begin
      ra = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ra = NA'($urandom_range(0, 1000));
      case ($urandom_range(0, 9))
        0:       rb = '0;
        1, 2, 3: rb = NB'($urandom_range(1, 15));
        default: rb = NB'($urandom);
      endcase
      run_op("rand", ra, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
